// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types: FSM states, queue entry layout, word size.
package cpu_fetch_pkg;

   typedef enum logic [1:0] {
      S_FETCH,
      S_FULL,
      S_FLUSH
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
   } fetch_entry_t;

   localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetched words with their PCs.
// Clear wins over push and pop in the same cycle.
module fetch_fifo
   import cpu_fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int OW = AW + 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         clear,
   output fetch_entry_t head,
   output logic [OW-1:0] occupancy
);

   fetch_entry_t   store [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         occupancy <= occupancy + OW'(push) - OW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push && !clear) store[wr_ptr] <= push_entry;
   end

   assign head = store[rd_ptr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with credit-limited issue and redirect flush.
// Optional combinational bypass of the inflight word: PREFETCH_BYPASS_EN.
module instr_prefetch_queue
   import cpu_fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'd0,
   localparam int         OW       = $clog2(DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset,
   output logic [31:0]   mem_raddress,
   input  logic [31:0]   mem_rdata,
   input  logic          redirect,
   input  logic [63:0]   redirect_pc,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [31:0]   instr_data,
   output logic [63:0]   instr_pc,
   output logic [OW-1:0] occupancy,
   output logic          misalign_err
);

   localparam int          SW      = OW + 1;
   localparam logic [SW-1:0] DEPTH_C = SW'(DEPTH);

   fetch_state_t  state;
   logic [63:0]   fetch_pc;
   logic [63:0]   inflight_pc;
   logic          inflight;
   fetch_entry_t  head;
   fetch_entry_t  last_q;
   fetch_entry_t  cap_entry;
   logic [OW-1:0] fifo_occ;
   logic [SW-1:0] credit_sum;
   logic [SW-1:0] next_sum;
   logic          fifo_nempty;
   logic          issue;
   logic          kill;
   logic          bypass;
   logic          push;
   logic          pop;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_entry (cap_entry),
      .pop        (pop),
      .clear      (redirect),
      .head       (head),
      .occupancy  (fifo_occ)
   );

   always_comb begin
      fifo_nempty = fifo_occ != '0;
      kill        = redirect || (state == S_FLUSH);
      // Inflight word holds a slot already, so capture never overflows.
      credit_sum  = {1'b0, fifo_occ} + SW'(inflight);
      issue       = (state == S_FETCH) && (credit_sum < DEPTH_C) && !redirect;
`ifdef PREFETCH_BYPASS_EN
      bypass      = inflight && !kill && !fifo_nempty && instr_ready;
`else
      bypass      = 1'b0;
`endif
      push        = inflight && !kill && !bypass;
      pop         = fifo_nempty && instr_ready && !redirect;
      next_sum    = {1'b0, fifo_occ} + SW'(push) - SW'(pop) + SW'(issue);
      cap_entry   = '{instr: mem_rdata, pc: inflight_pc};
   end

   always_comb begin
      instr_valid = fifo_nempty || bypass;
      if (fifo_nempty) begin
         instr_data = head.instr;
         instr_pc   = head.pc;
      end else if (bypass) begin
         instr_data = mem_rdata;
         instr_pc   = inflight_pc;
      end else begin
         instr_data = last_q.instr;
         instr_pc   = last_q.pc;
      end
      occupancy    = fifo_occ;
      mem_raddress = fetch_pc[31:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_FETCH;
         fetch_pc     <= RESET_PC;
         inflight     <= 1'b0;
         inflight_pc  <= '0;
         last_q       <= '0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
         inflight     <= issue;
         if (issue) inflight_pc <= fetch_pc;
         if (redirect) begin
            fetch_pc <= {redirect_pc[63:2], 2'b00};
            state    <= S_FLUSH;
         end else begin
            if (issue) fetch_pc <= fetch_pc + 64'(INSTR_BYTES);
            if (state == S_FLUSH) state <= S_FETCH;
            else state <= (next_sum == DEPTH_C) ? S_FULL : S_FETCH;
         end
         // Remember the last consumed word so the outputs hold when empty.
         if (instr_valid && instr_ready && !redirect)
            last_q <= '{instr: instr_data, pc: instr_pc};
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: directed scenarios plus a
// randomized run scored against an in-order PC stream model.
module tb_instr_prefetch_queue;

   localparam int DEPTH = 4;
   localparam int OW    = $clog2(DEPTH) + 1;
`ifdef PREFETCH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic [31:0]   mem_raddress;
   logic [31:0]   mem_rdata;
   logic          redirect;
   logic [63:0]   redirect_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic [31:0]   instr_data;
   logic [63:0]   instr_pc;
   logic [OW-1:0] occupancy;
   logic          misalign_err;

   int errors = 0;
   int checks = 0;
   bit use_nop = 1'b0;

   always #5 clock = ~clock;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (use_nop) return 32'h0000_0013;
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000 ^ a;
   endfunction

   always @(posedge clock) mem_rdata <= word_at(mem_raddress);

   instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'd0)) dut (
      .clock        (clock),
      .reset        (reset),
      .mem_raddress (mem_raddress),
      .mem_rdata    (mem_rdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_data   (instr_data),
      .instr_pc     (instr_pc),
      .occupancy    (occupancy),
      .misalign_err (misalign_err)
   );

   task automatic apply_reset();
      @(negedge clock);
      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset       = 1'b0;
      instr_ready = 1'b1;
      #1;
      checks += 6;
      if (instr_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", instr_valid);
      end
      if (instr_data !== 32'd0) begin
         errors++; $display("FAIL reset_data: got %h want 0", instr_data);
      end
      if (instr_pc !== 64'd0) begin
         errors++; $display("FAIL reset_pc: got %h want 0", instr_pc);
      end
      if (occupancy !== '0) begin
         errors++; $display("FAIL reset_occ: got %0d want 0", occupancy);
      end
      if (misalign_err !== 1'b0) begin
         errors++; $display("FAIL reset_mis: got %b want 0", misalign_err);
      end
      if (mem_raddress !== 32'd0) begin
         errors++; $display("FAIL reset_raddr: got %h want 0", mem_raddress);
      end
   endtask

   task automatic test_latency();
      int first_c;
      int idx;
      use_nop = 1'b1;
      apply_reset();
      instr_ready = 1'b1;
      reset = 1'b1;
      #1;
      checks += 2;
      if (instr_valid !== 1'b0) begin
         errors++; $display("FAIL lat_c0_valid: got %b want 0", instr_valid);
      end
      if (mem_raddress !== 32'd0) begin
         errors++; $display("FAIL lat_c0_raddr: got %h want 0", mem_raddress);
      end
      first_c = BYPASS ? 1 : 2;
      idx = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock); #1;
         if (c < first_c) begin
            checks++;
            if (instr_valid !== 1'b0) begin
               errors++; $display("FAIL lat_early_valid c%0d: got %b want 0", c, instr_valid);
            end
         end else if (idx < 4) begin
            checks += 3;
            if (instr_valid !== 1'b1) begin
               errors++; $display("FAIL lat_valid c%0d: got %b want 1", c, instr_valid);
            end
            if (instr_pc !== 64'(idx * 4)) begin
               errors++; $display("FAIL lat_pc c%0d: got %h want %h", c, instr_pc, idx * 4);
            end
            if (instr_data !== 32'h13) begin
               errors++; $display("FAIL lat_data c%0d: got %h want 00000013", c, instr_data);
            end
            idx++;
         end
      end
      use_nop = 1'b0;
   endtask

   task automatic test_fill();
      apply_reset();
      reset = 1'b1;
      repeat (9) begin @(negedge clock); #1; end
      checks++;
      if (mem_raddress !== 32'h10) begin
         errors++; $display("FAIL fill_raddr9: got %h want 00000010", mem_raddress);
      end
      @(negedge clock); #1;
      checks += 3;
      if (mem_raddress !== 32'h10) begin
         errors++; $display("FAIL fill_raddr10: got %h want 00000010", mem_raddress);
      end
      if (occupancy !== OW'(DEPTH)) begin
         errors++; $display("FAIL fill_occ: got %0d want %0d", occupancy, DEPTH);
      end
      if (instr_valid !== 1'b1) begin
         errors++; $display("FAIL fill_valid: got %b want 1", instr_valid);
      end
      @(negedge clock);
      instr_ready = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin @(negedge clock); #1; end
         checks += 3;
         if (instr_valid !== 1'b1) begin
            errors++; $display("FAIL drain_valid %0d: got %b want 1", i, instr_valid);
         end
         if (instr_pc !== 64'(i * 4)) begin
            errors++; $display("FAIL drain_pc %0d: got %h want %h", i, instr_pc, i * 4);
         end
         if (instr_data !== word_at(32'(i * 4))) begin
            errors++; $display("FAIL drain_data %0d: got %h want %h", i, instr_data, word_at(32'(i * 4)));
         end
      end
   endtask

   // Collects n deliveries from the current path; any stale word fails.
   task automatic expect_stream(input string tag, input logic [63:0] start, input int n);
      logic [63:0] exp_pc;
      int got;
      exp_pc = start;
      got = 0;
      for (int c = 0; c < 20 && got < n; c++) begin
         @(negedge clock); #1;
         if (instr_valid && instr_ready) begin
            checks += 2;
            if (instr_pc !== exp_pc) begin
               errors++; $display("FAIL %s_pc: got %h want %h", tag, instr_pc, exp_pc);
            end
            if (instr_data !== word_at(exp_pc[31:0])) begin
               errors++; $display("FAIL %s_data: got %h want %h", tag, instr_data, word_at(exp_pc[31:0]));
            end
            exp_pc += 64'd4;
            got++;
         end
      end
      checks++;
      if (got != n) begin
         errors++; $display("FAIL %s_count: got %0d want %0d", tag, got, n);
      end
   endtask

   task automatic test_redirect();
      bit hit;
      apply_reset();
      reset = 1'b1;
      hit = 1'b0;
      for (int n = 0; n < 20 && !hit; n++) begin
         @(negedge clock); #1;
         if (occupancy == 3) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         errors++; $display("FAIL redir_reach_occ3: got none want 3");
      end
      redirect    = 1'b1;
      redirect_pc = 64'h100;
      @(negedge clock);
      redirect = 1'b0;
      #1;
      checks += 3;
      if (occupancy !== '0) begin
         errors++; $display("FAIL redir_occ: got %0d want 0", occupancy);
      end
      if (instr_valid !== 1'b0) begin
         errors++; $display("FAIL redir_valid: got %b want 0", instr_valid);
      end
      if (misalign_err !== 1'b0) begin
         errors++; $display("FAIL redir_mis: got %b want 0", misalign_err);
      end
      instr_ready = 1'b1;
      expect_stream("redir", 64'h100, 2);
   endtask

   task automatic test_misalign();
      apply_reset();
      instr_ready = 1'b1;
      reset = 1'b1;
      repeat (6) @(negedge clock);
      redirect    = 1'b1;
      redirect_pc = 64'h203;
      #1;
      checks++;
      if (misalign_err !== 1'b0) begin
         errors++; $display("FAIL mis_before: got %b want 0", misalign_err);
      end
      @(negedge clock);
      redirect = 1'b0;
      #1;
      checks++;
      if (misalign_err !== 1'b1) begin
         errors++; $display("FAIL mis_pulse: got %b want 1", misalign_err);
      end
      @(negedge clock); #1;
      checks++;
      if (misalign_err !== 1'b0) begin
         errors++; $display("FAIL mis_after: got %b want 0", misalign_err);
      end
      expect_stream("mis", 64'h200, 2);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      instr_ready = 1'b1;
      reset = 1'b1;
      repeat (6) @(negedge clock);
      redirect    = 1'b1;
      redirect_pc = 64'h40;
      @(negedge clock);
      redirect_pc = 64'h80;
      @(negedge clock);
      redirect = 1'b0;
      expect_stream("b2b", 64'h80, 3);
   endtask

   task automatic test_reset_midop();
      bit hit;
      apply_reset();
      reset = 1'b1;
      hit = 1'b0;
      for (int n = 0; n < 20 && !hit; n++) begin
         @(negedge clock); #1;
         if (occupancy == 2) hit = 1'b1;
      end
      reset = 1'b0;
      #1;
      checks += 5;
      if (!hit) begin
         errors++; $display("FAIL mid_reach_occ2: got none want 2");
      end
      if (instr_valid !== 1'b0) begin
         errors++; $display("FAIL mid_valid: got %b want 0", instr_valid);
      end
      if (occupancy !== '0) begin
         errors++; $display("FAIL mid_occ: got %0d want 0", occupancy);
      end
      if (mem_raddress !== 32'd0) begin
         errors++; $display("FAIL mid_raddr: got %h want 0", mem_raddress);
      end
      if (instr_pc !== 64'd0 || instr_data !== 32'd0) begin
         errors++; $display("FAIL mid_head: got %h/%h want 0/0", instr_pc, instr_data);
      end
      @(negedge clock);
      reset = 1'b1;
      instr_ready = 1'b1;
      expect_stream("mid", 64'd0, 3);
   endtask

   task automatic test_random();
      logic [63:0] exp_pc;
      logic [63:0] rpc;
      bit prev_mis;
      int delivered;
      apply_reset();
      reset = 1'b1;
      exp_pc = 64'd0;
      prev_mis = 1'b0;
      delivered = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clock);
         redirect = ($urandom_range(0, 49) == 0);
         rpc = {$urandom(), $urandom()};
         if ($urandom_range(0, 3) == 0)
            rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         redirect_pc = rpc;
         if ((cyc % 400) < 60) instr_ready = ($urandom_range(0, 7) == 0);
         else instr_ready = ($urandom_range(0, 3) != 0);
         #1;
         checks += 2;
         if (misalign_err !== prev_mis) begin
            errors++; $display("FAIL rnd_mis cyc%0d: got %b want %b", cyc, misalign_err, prev_mis);
         end
         if (occupancy > OW'(DEPTH)) begin
            errors++; $display("FAIL rnd_occ cyc%0d: got %0d want <=%0d", cyc, occupancy, DEPTH);
         end
         if (!BYPASS) begin
            checks++;
            if (instr_valid !== (occupancy != '0)) begin
               errors++; $display("FAIL rnd_valid cyc%0d: got %b want %b", cyc, instr_valid, occupancy != '0);
            end
         end
         if (instr_valid && instr_ready && !redirect) begin
            checks += 2;
            if (instr_pc !== exp_pc) begin
               errors++; $display("FAIL rnd_pc cyc%0d: got %h want %h", cyc, instr_pc, exp_pc);
            end
            if (instr_data !== word_at(exp_pc[31:0])) begin
               errors++; $display("FAIL rnd_data cyc%0d: got %h want %h", cyc, instr_data, word_at(exp_pc[31:0]));
            end
            exp_pc += 64'd4;
            delivered++;
         end
         prev_mis = redirect && (rpc[1:0] != 2'b00);
         if (redirect) exp_pc = {rpc[63:2], 2'b00};
      end
      @(negedge clock);
      redirect = 1'b0;
      checks++;
      if (delivered < 300) begin
         errors++; $display("FAIL rnd_throughput: got %0d want >=300", delivered);
      end
   endtask

   initial begin
      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      test_reset();
      test_latency();
      test_fill();
      test_redirect();
      test_misalign();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Instruction fetch front end between the 32-bit instruction memory (registered read, 1-cycle latency) and the CPU instruction register.
- Owns the fetch PC and issues sequential word reads at +4.
- Buffers returned words with their PCs in a small FIFO and presents them to the control unit over a valid/ready handshake.
- On a taken branch or jump, the CPU pulses redirect; the queue flushes and refetches from the new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 64'd0, first fetch address after reset.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- mem_raddress  out  32  instruction memory read address (fetch_pc[31:0]).
- mem_rdata  in  32  instruction memory data; valid the cycle after the address is issued.
- redirect  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  64  new fetch address, sampled when redirect=1.
- instr_valid  out  1  head entry available.
- instr_ready  in  1  consumer accepts head this cycle (load_ir).
- instr_data  out  32  head instruction word.
- instr_pc  out  64  PC of head instruction.
- occupancy  out  $clog2(DEPTH)+1  entries currently held.
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; state=S_FETCH.
  - Outputs: instr_valid=0, instr_data=0, instr_pc=0, occupancy=0, misalign_err=0, mem_raddress=RESET_PC[31:0].
  - Reset asserted mid-operation discards everything, including an inflight response.
- Issue:
  - issue = (state==S_FETCH) && (occupancy + inflight < DEPTH) && !redirect.
  - On issue, inflight<=1 and inflight_pc<=fetch_pc, then fetch_pc<=fetch_pc+4 (64-bit, wraps modulo 2^64). Otherwise inflight<=0.
- Capture:
  - When inflight=1 and not killed, {mem_rdata, inflight_pc} is written at the tail the next edge.
  - Capture cannot overflow: the credit check counts inflight.
- Pop:
  - instr_valid = occupancy!=0. Pop when instr_valid && instr_ready.
  - A pop frees credit only from the next cycle; the credit check uses registered occupancy.
  - instr_ready while empty is ignored.
- Simultaneous push and pop: occupancy unchanged; head and tail pointers both advance (mod DEPTH).
- Latency: first issue in the first cycle after reset deassert (C0); instr_valid=1 at C2. Steady state sustains 1 instruction/cycle with instr_ready held high.
- FSM:
  - S_FETCH: normal issue.
  - S_FULL: entered when occupancy+inflight==DEPTH; no issue; returns to S_FETCH when a pop lowers the sum.
  - S_FLUSH: one cycle after redirect; no issue, any arriving response is dropped; then S_FETCH.
- Redirect (any state):
  - Same edge: FIFO cleared, occupancy<=0, fetch_pc<={redirect_pc[63:2],2'b00}, inflight response killed, state<=S_FLUSH.
  - A pop in the redirect cycle is ignored.
  - The first new-path issue occurs 2 cycles after redirect.
  - redirect during S_FLUSH restarts the flush with the newer PC.
- misalign_err is registered: pulses high the cycle after a redirect with redirect_pc[1:0]!=0. The PC is still aligned down.
- instr_data and instr_pc are driven from the head entry and hold their last value while empty.

Optional Feature:
- PREFETCH_BYPASS_EN:
  - Defined: when FIFO is empty, an inflight response is not killed, and instr_ready=1, the response is presented combinationally (instr_valid=1, instr_data=mem_rdata, instr_pc=inflight_pc) and consumed without being written. First instruction is visible at C1.
  - Undefined: no bypass; every word passes through the FIFO (valid at C2).
  - Credit and flush rules are identical in both builds.

Decomposition:
- Shared package cpu_fetch_pkg:
  - typedef fetch_state_t {S_FETCH, S_FULL, S_FLUSH}.
  - typedef fetch_entry_t {logic [31:0] instr; logic [63:0] pc;}.
  - constant INSTR_BYTES=4.
- One sub-module: fetch_fifo, a parameterised DEPTH-entry FIFO of fetch_entry_t with push, pop, clear, occupancy. The top holds fetch_pc, the credit logic, the FSM and the bypass.

Test Plan:
- Reset release, memory words 0x00000013 at every address, instr_ready=1 -> instr_valid rises at C2 (C1 with bypass); instr_pc sequence 0,4,8,12 on consecutive cycles.
- instr_ready=0 for 10 cycles -> mem_raddress stops advancing after 0x10 (DEPTH=4), occupancy=4, state S_FULL; raise ready -> pcs 0,4,8,12,16 delivered with no gaps or duplicates.
- Redirect with redirect_pc=0x100 while occupancy=3 and a response is inflight -> next cycle occupancy=0, stale word never appears; next instr_pc=0x100, then 0x104.
- Redirect with redirect_pc=0x203 -> misalign_err pulses one cycle; first delivered instr_pc=0x200.
- Back-to-back redirects to 0x40 then 0x80 -> only the 0x80 path is delivered.
- reset pulsed low while occupancy=2 -> all outputs return to reset values immediately; refetch starts at RESET_PC.
